// File: rtl/fpu_pkg.sv
// Shared fp32 definitions for the FPU blocks: field widths, constants, state and class encodings.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;
  localparam int QNAN_BIT = 22;
  localparam int PROD_W   = 2 * (MAN_W + 1);

  localparam logic [31:0] FP_PINF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fsqr_state_t;

  typedef enum logic [1:0] {CLS_FINITE, CLS_ZERO, CLS_INF, CLS_NAN} fp_class_t;

  function automatic fp_class_t fp_classify(input logic [31:0] v);
    if (v[30:23] == 8'hFF) begin
      return (v[22:0] != '0) ? CLS_NAN : CLS_INF;
    end
    if (v[30:0] == '0) begin
      return CLS_ZERO;
    end
    return CLS_FINITE;
  endfunction

endpackage

// File: rtl/fsqr_norm_round.sv
// Normalise, round (half-up on magnitude) and pack a 48b significand product into fp32.
module fsqr_norm_round
  import fpu_pkg::*;
(
  input  logic [PROD_W-1:0] prod,
  input  logic [7:0]        ea,
  input  logic [1:0]        cls,
  input  logic              sign,
  input  logic [21:0]       payload,
  output logic [31:0]       y,
  output logic              ovf
);

  fp_class_t         c;
  logic [5:0]        se;
  logic signed [9:0] eyrt;
  logic [9:0]        dsh;
  logic [24:0]       top_bits;
  logic [24:0]       t;
  logic [8:0]        exp_f;
  logic [31:0]       sum;

  assign c = fp_class_t'(cls);

  always_comb begin
    se = '0;
    for (int i = 0; i < PROD_W; i++) begin
      if (prod[i]) se = 6'(47 - i);
    end
    // Hidden bit, 23 fraction bits and the round bit; lower product bits never affect half-up rounding.
    top_bits = 25'((prod << se) >> 23);
    eyrt     = $signed({1'b0, ea, 1'b0}) - $signed({4'b0, se}) - 10'sd126;
    dsh      = 10'd1 - $unsigned(eyrt);
    if (eyrt <= 0) begin
      t     = top_bits >> dsh;
      exp_f = {8'b0, t[24]};
    end else begin
      t     = top_bits;
      exp_f = eyrt[8:0];
    end
    // A fraction carry ripples straight into the exponent field.
    sum = {exp_f, t[23:1]} + 32'(t[0]);

    y   = {1'b0, sum[30:0]};
    ovf = 1'b0;
    if (c == CLS_NAN) begin
      y = {sign, 8'hFF, 1'b1, payload};
    end else if (c == CLS_INF) begin
      y = FP_PINF;
    end else if (c == CLS_ZERO) begin
      y = '0;
    end else if (sum[31:23] >= 9'd255) begin
      y   = FP_PINF;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fsqr_iter.sv
// Multi-cycle fp32 squarer y = x*x using a shift-add significand multiplier (BPC bits per cycle).
// Handshake: a transfer happens on a rising edge where valid && ready (rst low); x is sampled only
// on the accepting edge, and y/ovf stay stable while out_valid is high until out_ready takes them.
module fsqr_iter
  import fpu_pkg::*;
#(
  parameter int BPC = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic [1:0]  state_dbg
);

  localparam int N  = 24 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 24 + BPC;

  fsqr_state_t       state;
  fsqr_state_t       state_nx;
  logic [CW-1:0]     cnt;
  logic [PROD_W-1:0] acc;
  logic [23:0]       ma;
  logic [23:0]       mq;
  logic [7:0]        ea;
  logic              sgn;
  logic [21:0]       payload;
  fp_class_t         cls;
  logic [PW-1:0]     pp;
  logic [PROD_W-1:0] pp_sh;
  logic [31:0]       nr_y;
  logic              nr_ovf;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)          state_nx = MUL;
      MUL:     if (cnt == CW'(N - 1)) state_nx = NORM;
      NORM:                           state_nx = DONE;
      DONE:    if (out_ready)         state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  // Partial product of the multiplicand with the next BPC multiplier bits, placed at its weight.
  always_comb begin
    pp    = PW'(ma) * PW'(mq[BPC-1:0]);
    pp_sh = PROD_W'(pp) << (int'(cnt) * BPC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      ma      <= '0;
      mq      <= '0;
      ea      <= '0;
      sgn     <= 1'b0;
      payload <= '0;
      cls     <= CLS_FINITE;
      y       <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn     <= x[31];
            payload <= x[21:0];
            ma      <= {|x[30:23], x[22:0]};
            mq      <= {|x[30:23], x[22:0]};
            ea      <= (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
            cls     <= fp_classify(x);
            acc     <= '0;
            cnt     <= '0;
          end
        end
        MUL: begin
          acc <= acc + pp_sh;
          mq  <= mq >> BPC;
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          y   <= nr_y;
          ovf <= nr_ovf;
        end
        default: ;
      endcase
    end
  end

  fsqr_norm_round u_norm (
    .prod    (acc),
    .ea      (ea),
    .cls     (cls),
    .sign    (sgn),
    .payload (payload),
    .y       (nr_y),
    .ovf     (nr_ovf)
  );

endmodule
